elevator_ctrl_n: RTL

Parametrised elevator controller for N floors. It replaces the fixed 3-floor call decoder, elevator FSM, door FSM and people counter with a single block. It latches hall and cabin calls into a pending register, serves them in SCAN order (keeps direction while calls remain ahead), times door and travel on a 1 Hz tick enable, and counts occupancy with an overload alarm that holds the door open. It sits between the debounced button inputs and the multiplexed display driver.

---
 rtl/elevator_pkg.sv | 39 +++
 rtl/occupancy_counter.sv | 36 +++
 rtl/elevator_ctrl_n.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types, default parameters and call-search helpers for the elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    OPEN = 2'd2
  } state_e;

  localparam int DEF_FLOORS       = 3;
  localparam int DEF_MAX_PEOPLE   = 5;
  localparam int DEF_CNT_W        = 4;
  localparam int DEF_DOOR_TICKS   = 3;
  localparam int DEF_TRAVEL_TICKS = 2;
  localparam int MAX_FLOORS       = 16;

  // True when any pending call lies strictly above floor flr.
  function automatic logic any_above(input logic [MAX_FLOORS-1:0] pend,
                                     input logic [3:0]            flr);
    logic found;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
      if (i > 32'(flr) && pend[i]) found = 1'b1;
    end
    return found;
  endfunction

  // True when any pending call lies strictly below floor flr.
  function automatic logic any_below(input logic [MAX_FLOORS-1:0] pend,
                                     input logic [3:0]            flr);
    logic found;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
      if (i < 32'(flr) && pend[i]) found = 1'b1;
    end
    return found;
  endfunction

endpackage

// File: rtl/occupancy_counter.sv
// Saturating cabin occupancy counter with an overload flag.
module occupancy_counter #(
  parameter int CNT_W      = 4,
  parameter int MAX_PEOPLE = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             alarm
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: single-direction pulses only, clamped at both ends.
  always_comb begin
    count_d = count_q;
    if (en && inc && !dec && count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end else if (en && dec && !inc && count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign alarm = 32'(count_q) > MAX_PEOPLE;

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: call latching, SCAN scheduling, tick-timed travel and door.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int FLOORS       = DEF_FLOORS,
  parameter int MAX_PEOPLE   = DEF_MAX_PEOPLE,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DOOR_TICKS   = DEF_DOOR_TICKS,
  parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
  parameter int FLOOR_W      = $clog2(FLOORS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [FLOORS-1:0]  call_ext,
  input  logic [FLOORS-1:0]  call_int,
  input  logic               person_in,
  input  logic               person_out,
  output logic [FLOOR_W-1:0] floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [CNT_W-1:0]   count,
  output logic               alarm,
  output logic [FLOORS-1:0]  pending
);

  localparam int DOOR_W = $clog2(DOOR_TICKS + 1);
  localparam int TRAV_W = $clog2(TRAVEL_TICKS + 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
  localparam logic [DOOR_W-1:0]  DOOR_LOAD = DOOR_W'(DOOR_TICKS);
  localparam logic [TRAV_W-1:0]  TRAV_LAST = TRAV_W'(TRAVEL_TICKS - 1);

  state_e              state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d, floor_step;
  logic                dir_q, dir_d;
  logic [FLOORS-1:0]   pending_q, pending_d, calls;
  logic [DOOR_W-1:0]   door_q, door_d;
  logic [TRAV_W-1:0]   travel_q, travel_d;
  logic [MAX_FLOORS-1:0] pend_wide;
  logic [3:0]          here_w, step_w;
  logic                call_here;
  logic                ahead_here, behind_here, ahead_step;

  occupancy_counter #(
    .CNT_W      (CNT_W),
    .MAX_PEOPLE (MAX_PEOPLE)
  ) u_occupancy (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == OPEN),
    .inc   (person_in),
    .dec   (person_out),
    .count (count),
    .alarm (alarm)
  );

  // Next-state, call latching, travel and door timers.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    door_d   = door_q;
    travel_d = travel_q;

    // A call at the floor whose door is already open only extends the door time.
    calls     = call_ext | call_int;
    call_here = 1'b0;
    if (state_q == OPEN) begin
      call_here      = calls[floor_q];
      calls[floor_q] = 1'b0;
    end
    pending_d = pending_q | calls;

    pend_wide              = '0;
    pend_wide[FLOORS-1:0]  = pending_q;
    here_w                 = 4'(floor_q);

    floor_step = floor_q;
    if (dir_q && floor_q != TOP_FLOOR) begin
      floor_step = floor_q + FLOOR_W'(1);
    end else if (!dir_q && floor_q != '0) begin
      floor_step = floor_q - FLOOR_W'(1);
    end
    step_w = 4'(floor_step);

    ahead_here  = dir_q ? any_above(pend_wide, here_w) : any_below(pend_wide, here_w);
    behind_here = dir_q ? any_below(pend_wide, here_w) : any_above(pend_wide, here_w);
    ahead_step  = dir_q ? any_above(pend_wide, step_w) : any_below(pend_wide, step_w);

    unique case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          state_d = OPEN;
        end else if (ahead_here) begin
          state_d = MOVE;
        end else if (behind_here) begin
          dir_d   = ~dir_q;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (tick) begin
          if (travel_q == TRAV_LAST) begin
            travel_d = '0;
            floor_d  = floor_step;
            if (pending_q[floor_step]) state_d = OPEN;
            else if (!ahead_step)      state_d = IDLE;
          end else begin
            travel_d = travel_q + TRAV_W'(1);
          end
        end
      end
      OPEN: begin
        if (person_in || person_out || call_here) begin
          door_d = DOOR_LOAD;
        end else if (door_q == '0) begin
          if (alarm) door_d  = DOOR_LOAD;
          else       state_d = IDLE;
        end else if (tick) begin
          door_d = door_q - DOOR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Entering OPEN serves the floor: its call is dropped and the door timer armed.
    if (state_d == OPEN && state_q != OPEN) begin
      pending_d[floor_d] = 1'b0;
      door_d             = DOOR_LOAD;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      pending_q <= '0;
      door_q    <= '0;
      travel_q  <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      door_q    <= door_d;
      travel_q  <= travel_d;
    end
  end

  assign floor     = floor_q;
  assign dir_up    = dir_q;
  assign moving    = (state_q == MOVE);
  assign door_open = (state_q == OPEN);
  assign pending   = pending_q;

endmodule
